qenc_speed_meter: RTL and testbench
===================================

QENC_SPEED_METER -- requirements
Module: qenc_speed_meter

Interface
REQ-001 SHALL have parameter CNT_W, default 31, width of the period counter and of out_period.
REQ-002 SHALL have parameter AVG_LOG2, default 2; the averaging depth is 2^AVG_LOG2 samples, and the legal range is 0..4.
REQ-003 SHALL have parameter TIMEOUT, default 16777215; this is the cycle count without a measured event that declares a stop.
REQ-004 SHALL have parameter POS_W, default 32, the position counter width.
REQ-005 SHALL have port in_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port in_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have ports in_phA and in_phB, inputs, 1 bit each: raw asynchronous encoder phases.
REQ-008 SHALL have port in_mode, input, 1 bit: 0 measures between synced-A rising edges; 1 measures between every valid quadrature step.
REQ-009 SHALL have port in_clr_pos, input, 1 bit: synchronous clear of out_pos.
REQ-010 SHALL have port out_dir, output, 1 bit: 1 = forward, 0 = reverse.
REQ-011 SHALL have port out_pos, output, POS_W bits: signed position in quadrature steps.
REQ-012 SHALL have port out_period, output, CNT_W bits: averaged clocks per measured event; 0 when stopped.
REQ-013 SHALL have port out_valid, output, 1 bit: one-cycle strobe when out_period updates.
REQ-014 SHALL have port out_stopped, output, 1 bit: level, 1 while timed out.
REQ-015 SHALL have port out_err, output, 1 bit: one-cycle strobe on an illegal transition.

Function
REQ-016 SHALL synchronise each phase through 2 flops; decoding uses only the synced values plus one history flop per phase, so the event-cycle latency is 3 clocks from the pin change.
REQ-017 SHALL treat the (A,B) sequence 00->10->11->01->00 as +1 and the reverse sequence as -1.
REQ-018 SHALL treat a transition where both phases change in one cycle as illegal: out_err pulses, with no step, no direction change and no measured event.
REQ-019 SHALL update out_dir on every valid step, in both modes.
REQ-020 SHALL update out_pos by ±1 per valid step, wrapping modulo 2^POS_W.
REQ-021 SHALL, when in_clr_pos is asserted, load out_pos with 0 plus the same-cycle step (0, +1 or -1).
REQ-022 SHALL, in mode 0, define a measured event as a synced-A rising edge.
REQ-023 SHALL, in mode 1, define a measured event as any valid step.
REQ-024 SHALL implement an FSM with states IDLE, COUNT and STOPPED.
REQ-025 IDLE/STOPPED: the counter is held at 0; a measured event moves the FSM to COUNT with the counter at 0, and no sample is taken.
REQ-026 COUNT: the counter increments each clock and saturates at TIMEOUT.
REQ-027 COUNT, on a measured event: sample = counter+1 and counter <= 0, so events N clocks apart give sample N.
REQ-028 COUNT: when the counter reaches TIMEOUT-1 with no event, the FSM goes to STOPPED; history and sum clear, out_period <= 0, out_stopped <= 1, and out_valid pulses once.
REQ-029 SHALL clear out_stopped on the event that leaves STOPPED.
REQ-030 An event coinciding with the timeout cycle SHALL win: it is sampled and no stop occurs.
REQ-031 SHALL hold the history as 2^AVG_LOG2 samples and keep a running sum of width CNT_W+AVG_LOG2: sum <= sum + new - oldest, with no overflow possible.
REQ-032 SHALL compute out_period = sum >> AVG_LOG2 and register it together with out_valid, both 2 clocks after the event cycle.
REQ-033 SHALL suppress out_valid until 2^AVG_LOG2 samples have been accepted since leaving IDLE/STOPPED; out_period holds its previous value meanwhile.
REQ-034 SHALL, on any change of in_mode (detected by a registered copy), force IDLE and clear history, sum and fill count; out_pos and out_dir are unaffected.

Reset
REQ-035 SHALL, on in_rst high, asynchronously drive all flops to 0, put the FSM in IDLE and drive every output to 0.
REQ-036 SHALL, when reset is applied mid-measurement, discard any partial count; after release, the first event only arms COUNT.

Verification
REQ-037 Mode 1, forward steps every 100 clocks -> out_dir=1, out_pos +1 per step, first out_valid after the 5th step with out_period=100, a strobe every 100 clocks thereafter.
REQ-038 Mode 0, reverse, A period 400 clocks -> out_dir=0, out_pos -4 per A period, out_period=400.
REQ-039 TIMEOUT=1000, steps stop -> at 1000 clocks after the last event, out_stopped=1, out_period=0, a single out_valid; the next step clears out_stopped with no strobe.
REQ-040 Step interval changes 100->200 with AVG_LOG2=2 -> out_period reads 125, 150, 175, 200 on successive strobes.
REQ-041 Both phases toggled in the same cycle -> out_err pulses once; out_pos and out_dir are unchanged.
REQ-042 in_clr_pos coincident with a +1 step -> out_pos=1; in_rst pulsed mid-COUNT -> all outputs 0 and the FSM in IDLE.

Source files
------------

// File: rtl/qenc_speed_meter.sv
// Quadrature encoder decoder with position counter and averaged period meter.
// Measures clocks between A rising edges (mode 0) or between every step (mode 1).
module qenc_speed_meter #(
    parameter int unsigned CNT_W    = 31,
    parameter int unsigned AVG_LOG2 = 2,
    parameter int unsigned TIMEOUT  = 16777215,
    parameter int unsigned POS_W    = 32
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic             in_phA,
    input  logic             in_phB,
    input  logic             in_mode,
    input  logic             in_clr_pos,
    output logic             out_dir,
    output logic [POS_W-1:0] out_pos,
    output logic [CNT_W-1:0] out_period,
    output logic             out_valid,
    output logic             out_stopped,
    output logic             out_err
);

    localparam int unsigned DEPTH  = 1 << AVG_LOG2;
    localparam int unsigned PTR_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int unsigned SUM_W  = CNT_W + AVG_LOG2;
    localparam int unsigned FILL_W = AVG_LOG2 + 1;

    localparam logic [CNT_W-1:0]  TMO_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COUNT   = 2'd1,
        STOPPED = 2'd2
    } state_t;

    logic a_s1, a_s2, a_h;
    logic b_s1, b_s2, b_h;
    logic mode_q;

    logic [1:0] idx_cur, idx_prv, idx_diff;
    logic       step_fwd, step_rev, step_any, illegal;
    logic       a_rise, meas_evt, mode_chg;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             take_smp, arm_evt, stop_evt;

    logic             smp_v_q;
    logic [CNT_W-1:0] smp_q;

    logic [CNT_W-1:0]  hist_q [DEPTH];
    logic [PTR_W-1:0]  ptr_q, ptr_nxt;
    logic [SUM_W-1:0]  sum_q, sum_nxt;
    logic [FILL_W-1:0] fill_q, fill_inc;
    logic [CNT_W-1:0]  oldest;
    logic              hist_clr;

    // Position along the Gray cycle 00 -> 10 -> 11 -> 01.
    function automatic logic [1:0] gray_idx(input logic a, input logic b);
        case ({a, b})
            2'b00:   gray_idx = 2'd0;
            2'b10:   gray_idx = 2'd1;
            2'b11:   gray_idx = 2'd2;
            default: gray_idx = 2'd3;
        endcase
    endfunction

    // Two-flop synchronisers plus one history flop per phase.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            a_s1   <= 1'b0;
            a_s2   <= 1'b0;
            a_h    <= 1'b0;
            b_s1   <= 1'b0;
            b_s2   <= 1'b0;
            b_h    <= 1'b0;
            mode_q <= 1'b0;
        end else begin
            a_s1   <= in_phA;
            a_s2   <= a_s1;
            a_h    <= a_s2;
            b_s1   <= in_phB;
            b_s2   <= b_s1;
            b_h    <= b_s2;
            mode_q <= in_mode;
        end
    end

    assign idx_cur  = gray_idx(a_s2, b_s2);
    assign idx_prv  = gray_idx(a_h, b_h);
    assign idx_diff = idx_cur - idx_prv;
    assign step_fwd = (idx_diff == 2'd1);
    assign step_rev = (idx_diff == 2'd3);
    assign step_any = step_fwd | step_rev;
    assign illegal  = (idx_diff == 2'd2);
    assign a_rise   = a_s2 & ~a_h & ~illegal;
    assign meas_evt = mode_q ? step_any : a_rise;
    assign mode_chg = in_mode ^ mode_q;

    // Position, direction and illegal-transition strobe.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            out_pos <= '0;
            out_dir <= 1'b0;
            out_err <= 1'b0;
        end else begin
            out_err <= illegal;
            if (step_any) begin
                out_dir <= step_fwd;
            end
            if (in_clr_pos) begin
                out_pos <= step_fwd ? POS_W'(1) : (step_rev ? '1 : '0);
            end else if (step_fwd) begin
                out_pos <= out_pos + POS_W'(1);
            end else if (step_rev) begin
                out_pos <= out_pos - POS_W'(1);
            end
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Period FSM: arm on first event, sample on later ones, stop on timeout.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        take_smp = 1'b0;
        arm_evt  = 1'b0;
        stop_evt = 1'b0;
        if (mode_chg) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE, STOPPED: begin
                    cnt_d = '0;
                    if (meas_evt) begin
                        state_d = COUNT;
                        arm_evt = 1'b1;
                    end
                end
                COUNT: begin
                    if (meas_evt) begin
                        take_smp = 1'b1;
                        cnt_d    = '0;
                    end else if (cnt_q == TMO_LAST) begin
                        state_d  = STOPPED;
                        stop_evt = 1'b1;
                        cnt_d    = '0;
                    end else if (cnt_q != TMO_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            smp_v_q <= 1'b0;
            smp_q   <= '0;
        end else begin
            smp_v_q <= take_smp;
            if (take_smp) begin
                smp_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign oldest   = hist_q[ptr_q];
    assign sum_nxt  = sum_q + SUM_W'(smp_q) - SUM_W'(oldest);
    assign fill_inc = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
    assign ptr_nxt  = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);
    assign hist_clr = mode_chg | stop_evt;

    // Circular sample history with running sum; oldest slot is overwritten.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                hist_q[i] <= '0;
            end
            ptr_q  <= '0;
            sum_q  <= '0;
            fill_q <= '0;
        end else if (hist_clr) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                hist_q[i] <= '0;
            end
            ptr_q  <= '0;
            sum_q  <= '0;
            fill_q <= '0;
        end else if (smp_v_q) begin
            hist_q[ptr_q] <= smp_q;
            ptr_q         <= ptr_nxt;
            sum_q         <= sum_nxt;
            fill_q        <= fill_inc;
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            out_period  <= '0;
            out_valid   <= 1'b0;
            out_stopped <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (stop_evt) begin
                out_period  <= '0;
                out_valid   <= 1'b1;
                out_stopped <= 1'b1;
            end else if (smp_v_q && !mode_chg && fill_inc == FILL_FULL) begin
                out_period <= CNT_W'(sum_nxt >> AVG_LOG2);
                out_valid  <= 1'b1;
            end
            if (arm_evt) begin
                out_stopped <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_qenc_speed_meter.sv
// Bench for qenc_speed_meter: directed scenarios plus randomized step streams
// checked against an interval-averaging model of the encoder.
module tb_qenc_speed_meter;

    localparam int unsigned CNT_W    = 31;
    localparam int unsigned AVG_LOG2 = 2;
    localparam int unsigned TMO      = 1000;
    localparam int unsigned POS_W    = 32;
    localparam int          AVG_N    = 4;

    logic             in_clk = 1'b0;
    logic             in_rst, in_phA, in_phB, in_mode, in_clr_pos;
    logic             out_dir, out_valid, out_stopped, out_err;
    logic [POS_W-1:0] out_pos;
    logic [CNT_W-1:0] out_period;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model state: Gray index of the pins, position, averaging window.
    int m_idx, m_pos, m_last, m_err;
    bit m_dir, m_mode, m_armed, m_stopped;
    int m_hist[$];
    int exp_q[$];
    int got_q[$];
    int got_t[$];
    int err_cnt;

    qenc_speed_meter #(
        .CNT_W(CNT_W), .AVG_LOG2(AVG_LOG2), .TIMEOUT(TMO), .POS_W(POS_W)
    ) dut (
        .in_clk(in_clk), .in_rst(in_rst), .in_phA(in_phA), .in_phB(in_phB),
        .in_mode(in_mode), .in_clr_pos(in_clr_pos), .out_dir(out_dir),
        .out_pos(out_pos), .out_period(out_period), .out_valid(out_valid),
        .out_stopped(out_stopped), .out_err(out_err)
    );

    always #5 in_clk = ~in_clk;
    always @(posedge in_clk) cyc <= cyc + 1;

    always @(negedge in_clk) begin
        if (!in_rst) begin
            if (out_valid) begin
                got_q.push_back(int'(out_period));
                got_t.push_back(cyc);
            end
            if (out_err) err_cnt++;
        end
    end

    function automatic void model_reset(input bit mode);
        m_idx = 0; m_pos = 0; m_last = 0; m_err = 0;
        m_dir = 1'b0; m_mode = mode; m_armed = 1'b0; m_stopped = 1'b0;
        m_hist.delete(); exp_q.delete(); got_q.delete(); got_t.delete();
        err_cnt = 0;
    endfunction

    // kind: +1 forward, -1 reverse, 2 = both phases flipped at once.
    function automatic void model_apply(input int kind, input int t);
        int  old_idx;
        bit  evt;
        int  s;
        old_idx = m_idx;
        evt = 1'b0;
        if (kind == 2) begin
            m_idx = (m_idx + 2) % 4;
            m_err++;
        end else begin
            m_idx = (m_idx + kind + 4) % 4;
            m_pos += kind;
            m_dir = (kind > 0);
            evt = m_mode ? 1'b1 : ((old_idx == 0 && m_idx == 1) || (old_idx == 3 && m_idx == 2));
        end
        if (!evt) return;
        if (m_armed && (t - m_last) > int'(TMO)) begin
            exp_q.push_back(0);
            m_armed = 1'b0;
            m_stopped = 1'b1;
            m_hist.delete();
        end
        if (!m_armed) begin
            m_armed = 1'b1;
            m_stopped = 1'b0;
        end else begin
            m_hist.push_back(t - m_last);
            if (m_hist.size() > AVG_N) void'(m_hist.pop_front());
            if (m_hist.size() == AVG_N) begin
                s = 0;
                foreach (m_hist[i]) s += m_hist[i];
                exp_q.push_back(s / AVG_N);
            end
        end
        m_last = t;
    endfunction

    function automatic void model_finish(input int t);
        if (m_armed && (t - m_last) > int'(TMO)) begin
            exp_q.push_back(0);
            m_armed = 1'b0;
            m_stopped = 1'b1;
            m_hist.delete();
        end
    endfunction

    task automatic drive_pins();
        in_phA = (m_idx == 1 || m_idx == 2);
        in_phB = (m_idx == 2 || m_idx == 3);
    endtask

    task automatic do_reset(input bit mode);
        in_rst = 1'b1; in_phA = 1'b0; in_phB = 1'b0; in_clr_pos = 1'b0; in_mode = mode;
        repeat (3) @(posedge in_clk);
        #1 in_rst = 1'b0;
        model_reset(mode);
        repeat (4) @(posedge in_clk);
    endtask

    task automatic do_step(input int kind, input int gap);
        @(posedge in_clk);
        #1;
        model_apply(kind, cyc);
        drive_pins();
        repeat (gap) @(posedge in_clk);
    endtask

    task automatic test_reset();
        in_rst = 1'b1; in_phA = 1'b1; in_phB = 1'b0; in_mode = 1'b1; in_clr_pos = 1'b1;
        repeat (3) @(posedge in_clk);
        #1;
        n_tests++; if (out_pos !== '0)    begin n_fail++; $display("FAIL reset_pos got %0h exp 0", out_pos); end
        n_tests++; if (out_dir !== 1'b0)  begin n_fail++; $display("FAIL reset_dir got %b exp 0", out_dir); end
        n_tests++; if (out_period !== '0) begin n_fail++; $display("FAIL reset_period got %0d exp 0", out_period); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        n_tests++; if (out_stopped !== 1'b0) begin n_fail++; $display("FAIL reset_stopped got %b exp 0", out_stopped); end
        n_tests++; if (out_err !== 1'b0)  begin n_fail++; $display("FAIL reset_err got %b exp 0", out_err); end
    endtask

    task automatic test_mode1_fwd();
        do_reset(1'b1);
        for (int i = 0; i < 4; i++) do_step(1, 99);
        n_tests++; if (got_q.size() != 0) begin n_fail++; $display("FAIL m1_early_valid got %0d strobes exp 0", got_q.size()); end
        for (int i = 0; i < 4; i++) do_step(1, 99);
        #1;
        n_tests++; if (out_dir !== 1'b1) begin n_fail++; $display("FAIL m1_dir got %b exp 1", out_dir); end
        n_tests++; if (out_pos !== POS_W'(8)) begin n_fail++; $display("FAIL m1_pos got %0d exp 8", out_pos); end
        n_tests++; if (got_q.size() != 4) begin n_fail++; $display("FAIL m1_count got %0d exp 4", got_q.size()); end
        for (int i = 0; i < got_q.size(); i++) begin
            n_tests++; if (got_q[i] != 100) begin n_fail++; $display("FAIL m1_period[%0d] got %0d exp 100", i, got_q[i]); end
            if (i > 0) begin
                n_tests++;
                if (got_t[i] - got_t[i-1] != 100) begin
                    n_fail++; $display("FAIL m1_spacing[%0d] got %0d exp 100", i, got_t[i] - got_t[i-1]);
                end
            end
        end
    endtask

    task automatic test_mode0_rev();
        do_reset(1'b0);
        for (int i = 0; i < 24; i++) do_step(-1, 99);
        #1;
        n_tests++; if (out_dir !== 1'b0) begin n_fail++; $display("FAIL m0_dir got %b exp 0", out_dir); end
        n_tests++; if (out_pos !== POS_W'(-24)) begin n_fail++; $display("FAIL m0_pos got %0h exp %0h", out_pos, POS_W'(-24)); end
        n_tests++; if (got_q.size() != 2) begin n_fail++; $display("FAIL m0_count got %0d exp 2", got_q.size()); end
        for (int i = 0; i < got_q.size(); i++) begin
            n_tests++; if (got_q[i] != 400) begin n_fail++; $display("FAIL m0_period[%0d] got %0d exp 400", i, got_q[i]); end
        end
    endtask

    task automatic test_avg_step();
        int exp_v[5];
        exp_v = '{100, 125, 150, 175, 200};
        do_reset(1'b1);
        for (int i = 0; i < 4; i++) do_step(1, 99);
        for (int i = 0; i < 4; i++) do_step(1, 199);
        do_step(1, 10);
        n_tests++; if (got_q.size() != 5) begin n_fail++; $display("FAIL avg_count got %0d exp 5", got_q.size()); end
        for (int i = 0; i < 5 && i < got_q.size(); i++) begin
            n_tests++; if (got_q[i] != exp_v[i]) begin n_fail++; $display("FAIL avg_period[%0d] got %0d exp %0d", i, got_q[i], exp_v[i]); end
        end
    endtask

    task automatic test_timeout();
        do_reset(1'b1);
        for (int i = 0; i < 5; i++) do_step(1, 99);
        do_step(1, 0);
        repeat (989) @(posedge in_clk);
        #1;
        n_tests++; if (out_stopped !== 1'b0) begin n_fail++; $display("FAIL tmo_early_stop got %b exp 0", out_stopped); end
        n_tests++; if (got_q.size() != 2) begin n_fail++; $display("FAIL tmo_pre_count got %0d exp 2", got_q.size()); end
        repeat (20) @(posedge in_clk);
        #1;
        n_tests++; if (out_stopped !== 1'b1) begin n_fail++; $display("FAIL tmo_stopped got %b exp 1", out_stopped); end
        n_tests++; if (out_period !== '0) begin n_fail++; $display("FAIL tmo_period got %0d exp 0", out_period); end
        n_tests++; if (got_q.size() != 3) begin n_fail++; $display("FAIL tmo_strobes got %0d exp 3", got_q.size()); end
        do_step(1, 10);
        #1;
        n_tests++; if (out_stopped !== 1'b0) begin n_fail++; $display("FAIL tmo_restart got %b exp 0", out_stopped); end
        n_tests++; if (got_q.size() != 3) begin n_fail++; $display("FAIL tmo_restart_strobe got %0d exp 3", got_q.size()); end
        n_tests++; if (out_pos !== POS_W'(7)) begin n_fail++; $display("FAIL tmo_pos got %0d exp 7", out_pos); end
    endtask

    task automatic test_timeout_edge();
        do_reset(1'b1);
        for (int i = 0; i < 4; i++) do_step(1, 999);
        do_step(1, 10);
        #1;
        n_tests++; if (out_stopped !== 1'b0) begin n_fail++; $display("FAIL edge_stopped got %b exp 0", out_stopped); end
        n_tests++; if (got_q.size() != 1) begin n_fail++; $display("FAIL edge_count got %0d exp 1", got_q.size()); end
        if (got_q.size() > 0) begin
            n_tests++; if (got_q[0] != int'(TMO)) begin n_fail++; $display("FAIL edge_period got %0d exp %0d", got_q[0], TMO); end
        end
    endtask

    task automatic test_illegal();
        do_reset(1'b1);
        for (int i = 0; i < 3; i++) do_step(1, 20);
        do_step(2, 20);
        #1;
        n_tests++; if (err_cnt != 1) begin n_fail++; $display("FAIL ill_err got %0d pulses exp 1", err_cnt); end
        n_tests++; if (out_pos !== POS_W'(3)) begin n_fail++; $display("FAIL ill_pos got %0d exp 3", out_pos); end
        n_tests++; if (out_dir !== 1'b1) begin n_fail++; $display("FAIL ill_dir got %b exp 1", out_dir); end
        do_step(-1, 20);
        #1;
        n_tests++; if (out_pos !== POS_W'(m_pos)) begin n_fail++; $display("FAIL ill_after_pos got %0d exp %0d", out_pos, m_pos); end
        n_tests++; if (out_dir !== m_dir) begin n_fail++; $display("FAIL ill_after_dir got %b exp %b", out_dir, m_dir); end
    endtask

    task automatic test_clr_pos();
        do_reset(1'b1);
        for (int i = 0; i < 3; i++) do_step(1, 20);
        @(posedge in_clk);
        #1;
        model_apply(1, cyc);
        drive_pins();
        repeat (2) @(posedge in_clk);
        #1 in_clr_pos = 1'b1;
        @(posedge in_clk);
        #1 in_clr_pos = 1'b0;
        repeat (3) @(posedge in_clk);
        #1;
        n_tests++; if (out_pos !== POS_W'(1)) begin n_fail++; $display("FAIL clr_step_pos got %0d exp 1", out_pos); end
        in_clr_pos = 1'b1;
        @(posedge in_clk);
        #1 in_clr_pos = 1'b0;
        #1;
        n_tests++; if (out_pos !== '0) begin n_fail++; $display("FAIL clr_pos got %0d exp 0", out_pos); end
    endtask

    task automatic test_reset_mid();
        do_reset(1'b1);
        for (int i = 0; i < 2; i++) do_step(1, 99);
        do_step(1, 50);
        in_rst = 1'b1; in_phA = 1'b0; in_phB = 1'b0;
        repeat (2) @(posedge in_clk);
        #1;
        n_tests++; if (out_pos !== '0) begin n_fail++; $display("FAIL mid_pos got %0d exp 0", out_pos); end
        n_tests++; if (out_dir !== 1'b0) begin n_fail++; $display("FAIL mid_dir got %b exp 0", out_dir); end
        n_tests++; if (out_stopped !== 1'b0) begin n_fail++; $display("FAIL mid_stopped got %b exp 0", out_stopped); end
        n_tests++; if (out_period !== '0) begin n_fail++; $display("FAIL mid_period got %0d exp 0", out_period); end
        in_rst = 1'b0;
        model_reset(1'b1);
        repeat (4) @(posedge in_clk);
        for (int i = 0; i < 4; i++) do_step(1, 99);
        n_tests++; if (got_q.size() != 0) begin n_fail++; $display("FAIL mid_rearm got %0d strobes exp 0", got_q.size()); end
        do_step(1, 10);
        n_tests++; if (got_q.size() != 1) begin n_fail++; $display("FAIL mid_first got %0d strobes exp 1", got_q.size()); end
        if (got_q.size() > 0) begin
            n_tests++; if (got_q[0] != 100) begin n_fail++; $display("FAIL mid_period1 got %0d exp 100", got_q[0]); end
        end
    endtask

    task automatic test_random();
        int n_steps, r, pref, gap;
        for (int it = 0; it < 6; it++) begin
            do_reset(1'($urandom_range(0, 1)));
            n_steps = $urandom_range(20, 40);
            pref = 1;
            for (int s = 0; s < n_steps; s++) begin
                r = $urandom_range(0, 19);
                if (r == 0) pref = -pref;
                gap = $urandom_range(20, 200);
                if (r == 1) do_step(2, gap);
                else if (r < 5) do_step(-pref, gap);
                else do_step(pref, gap);
            end
            repeat (TMO + 50) @(posedge in_clk);
            #1;
            model_finish(cyc);
            n_tests++; if (out_pos !== POS_W'(m_pos)) begin n_fail++; $display("FAIL rnd%0d_pos got %0d exp %0d", it, out_pos, POS_W'(m_pos)); end
            n_tests++; if (out_dir !== m_dir) begin n_fail++; $display("FAIL rnd%0d_dir got %b exp %b", it, out_dir, m_dir); end
            n_tests++; if (err_cnt != m_err) begin n_fail++; $display("FAIL rnd%0d_err got %0d exp %0d", it, err_cnt, m_err); end
            n_tests++; if (out_stopped !== m_stopped) begin n_fail++; $display("FAIL rnd%0d_stopped got %b exp %b", it, out_stopped, m_stopped); end
            n_tests++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rnd%0d_count got %0d exp %0d", it, got_q.size(), exp_q.size()); end
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
                n_tests++;
                if (got_q[i] != exp_q[i]) begin
                    n_fail++; $display("FAIL rnd%0d_period[%0d] got %0d exp %0d", it, i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_mode1_fwd();
        test_mode0_rev();
        test_avg_step();
        test_timeout();
        test_timeout_edge();
        test_illegal();
        test_clr_pos();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
